// File: rtl/length_counter_bank.sv
// Bank of NCH length counters. Each counter is loaded from the shared 32-entry decode ROM,
// cleared when its enable bit drops, and stepped down on half-frame ticks unless halted.
module length_counter_bank #(
  parameter int NCH          = 4,
  parameter int CNT_W        = 8,
  parameter bit RELOAD_QUIRK = 1'b1
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NCH-1:0]     load_ch,
  input  logic [4:0]         load_idx,
  input  logic               en_wr,
  input  logic [NCH-1:0]     en_data,
  input  logic [NCH-1:0]     halt,
  input  logic               tick,
  output logic [NCH-1:0]     active,
  output logic [NCH-1:0]     expired,
  output logic [NCH*CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   en_next;
  logic [NCH-1:0]   exp_d;
  logic [7:0]       rom_val;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    rom_val = 8'd0;
    case (load_idx)
      5'd0:  rom_val = 8'd10;   5'd1:  rom_val = 8'd254;
      5'd2:  rom_val = 8'd20;   5'd3:  rom_val = 8'd2;
      5'd4:  rom_val = 8'd40;   5'd5:  rom_val = 8'd4;
      5'd6:  rom_val = 8'd80;   5'd7:  rom_val = 8'd6;
      5'd8:  rom_val = 8'd160;  5'd9:  rom_val = 8'd8;
      5'd10: rom_val = 8'd60;   5'd11: rom_val = 8'd10;
      5'd12: rom_val = 8'd14;   5'd13: rom_val = 8'd12;
      5'd14: rom_val = 8'd26;   5'd15: rom_val = 8'd14;
      5'd16: rom_val = 8'd12;   5'd17: rom_val = 8'd16;
      5'd18: rom_val = 8'd24;   5'd19: rom_val = 8'd18;
      5'd20: rom_val = 8'd48;   5'd21: rom_val = 8'd20;
      5'd22: rom_val = 8'd96;   5'd23: rom_val = 8'd22;
      5'd24: rom_val = 8'd192;  5'd25: rom_val = 8'd24;
      5'd26: rom_val = 8'd72;   5'd27: rom_val = 8'd26;
      5'd28: rom_val = 8'd16;   5'd29: rom_val = 8'd28;
      5'd30: rom_val = 8'd32;   5'd31: rom_val = 8'd30;
      default: rom_val = 8'd0;
    endcase
  end

  assign load_val = CNT_W'(rom_val);

  // Loads see the enable value written in the same cycle.
  assign en_next = en_wr ? en_data : en_q;

  always_comb begin
    exp_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!en_next[i]) begin
        cnt_d[i] = '0;
      end else if (load_ch[i] && !(RELOAD_QUIRK && tick && (cnt_q[i] != '0))) begin
        cnt_d[i] = load_val;
      end else if (tick && !halt[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        exp_d[i] = (cnt_q[i] == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      en_q    <= '0;
      expired <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      en_q    <= en_next;
      expired <= exp_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      count[i*CNT_W +: CNT_W] = cnt_q[i];
      active[i]               = (cnt_q[i] != '0);
    end
  end

endmodule
